// File: rtl/kbd_spi_matrix.sv
// kbd_spi_matrix: receives the 40-key ZX keyboard matrix from the PS/2 MCU
// over a CS/CLK/DI serial link and serves the port #FE key column read.
// Bit n of a frame lands at row n/5, column n%5; a frame is committed only
// when exactly FRAME_BITS bits were clocked between CS fall and CS rise.
module kbd_spi_matrix #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 40
) (
    input  logic       CLK_14MHZ,
    input  logic       RESET,
    input  logic       KBD_CLK,
    input  logic       KBD_DI,
    input  logic       KBD_CS,
    input  logic [7:0] A_HI,
    output logic [4:0] KEYS,
    output logic       FRAME_OK,
    output logic       FRAME_ERR,
    output logic [3:0] ERR_CNT
);

    localparam int MAT_BITS = 40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Line bundle: [2] = CS, [1] = DI, [0] = CLK
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0]                  dly_q, dly_d;

    state_t              state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [MAT_BITS-1:0] shadow_q, shadow_d;
    logic [MAT_BITS-1:0] matrix_q, matrix_d;
    logic                frame_ok_q, frame_ok_d;
    logic                frame_err_q, frame_err_d;
    logic [3:0]          err_cnt_q, err_cnt_d;

    logic                cs_s;
    logic                cs_fall_s;
    logic                cs_rise_s;
    logic                clk_rise_s;
    logic                di_s;
    logic [4:0]          keys_s;

    // Synchronizer chains plus one delay register per line for edge detection
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {KBD_CS, KBD_DI, KBD_CLK};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d = sync_q[SYNC_STAGES-1];
    end

    // Edge detection on the synchronized lines
    always_comb begin
        cs_s       = sync_q[SYNC_STAGES-1][2];
        di_s       = sync_q[SYNC_STAGES-1][1];
        cs_fall_s  = ~cs_s & dly_q[2];
        cs_rise_s  = cs_s & ~dly_q[2];
        clk_rise_s = sync_q[SYNC_STAGES-1][0] & ~dly_q[0];
    end

    // Frame FSM: receive into the shadow register, then commit or reject
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        matrix_d    = matrix_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    cnt_d   = 6'd0;
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                // CS rise has priority; a coincident clock edge is dropped
                if (cs_rise_s) begin
                    state_d = ST_COMMIT;
                end else if (clk_rise_s) begin
                    shadow_d = {shadow_q[MAT_BITS-2:0], di_s};
                    if (cnt_q != 6'd63) begin
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_COMMIT: begin
                if (cnt_q == 6'(FRAME_BITS)) begin
                    // First received bit sits at the shadow MSB
                    for (int n = 0; n < MAT_BITS; n++) begin
                        matrix_d[n] = shadow_q[MAT_BITS-1-n];
                    end
                    frame_ok_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                    if (err_cnt_q != 4'd15) begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end
                // A CS fall seen during the commit cycle opens the next frame
                if (cs_fall_s) begin
                    cnt_d   = 6'd0;
                    state_d = ST_RECV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; sync chains reset low so a CS held low
    // across reset release never looks like a falling edge
    always_ff @(posedge CLK_14MHZ or posedge RESET) begin
        if (RESET) begin
            sync_q      <= '0;
            dly_q       <= 3'b000;
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            shadow_q    <= {MAT_BITS{1'b1}};
            matrix_q    <= {MAT_BITS{1'b1}};
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 4'd0;
        end else begin
            sync_q      <= sync_d;
            dly_q       <= dly_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            matrix_q    <= matrix_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Port #FE read: AND the selected half-rows column by column
    always_comb begin
        keys_s = 5'b11111;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (A_HI[r] == 1'b0) begin
                    keys_s[c] = keys_s[c] & matrix_q[r*5+c];
                end else begin
                    keys_s[c] = keys_s[c];
                end
            end
        end
    end

    assign KEYS      = keys_s;
    assign FRAME_OK  = frame_ok_q;
    assign FRAME_ERR = frame_err_q;
    assign ERR_CNT   = err_cnt_q;

endmodule
